// File: rtl/coef_mac_pkg.sv
// Shared encodings and default widths for the coefficient MAC sequencer.
package coef_mac_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAP1 = 2'd1,
    TAP2 = 2'd2,
    TAP3 = 2'd3
  } state_e;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_A1A  = 2'b01;
  localparam logic [1:0] SEL_A1M  = 2'b10;
  localparam logic [1:0] SEL_A1B  = 2'b11;

endpackage

// File: rtl/coef_mac_seq_if.sv
// Sample/coefficient/result bundle between the filter datapath and coef_mac_seq.
interface coef_mac_seq_if
  import coef_mac_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic                     start;
  logic signed [DATA_W-1:0] sample_in;
  logic        [WIDTH-1:0]  coef_in;
  logic        [1:0]        sel;
  logic                     busy;
  logic                     done;
  logic signed [ACC_W-1:0]  y_out;
  logic                     ovf;

  modport master (
    output start, sample_in, coef_in,
    input  sel, busy, done, y_out, ovf
  );

  modport slave (
    input  start, sample_in, coef_in,
    output sel, busy, done, y_out, ovf
  );

endinterface

// File: rtl/sample_delay_line.sv
// Three-deep signed sample history; shifts one position per enabled clock.
module sample_delay_line
  import coef_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] x0_o,
  output logic signed [DATA_W-1:0] x1_o,
  output logic signed [DATA_W-1:0] x2_o
);

  logic signed [DATA_W-1:0] x0_q, x1_q, x2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else if (shift_en_i) begin
      x2_q <= x1_q;
      x1_q <= x0_q;
      x0_q <= din_i;
    end
  end

  assign x0_o = x0_q;
  assign x1_o = x1_q;
  assign x2_o = x2_q;

endmodule

// File: rtl/coef_mac_seq.sv
// Three-tap FIR sequencer: walks sel over the taps and accumulates coef*sample.
// Optional output clamp to the sample range when COEF_MAC_SAT_EN is defined.
module coef_mac_seq
  import coef_mac_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  coef_mac_seq_if.slave  bus
);

  localparam int PROD_W = DATA_W + WIDTH + 1;

  state_e                   state_q, state_d;
  logic        [1:0]        sel_q, sel_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     shift_en;

  logic signed [DATA_W-1:0] x0, x1, x2, x_tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  y_fin;
  logic                     sat_hit;

  sample_delay_line #(.DATA_W(DATA_W)) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en_i(shift_en),
    .din_i     (bus.sample_in),
    .x0_o      (x0),
    .x1_o      (x1),
    .x2_o      (x2)
  );

  always_comb begin
    x_tap = '0;
    case (state_q)
      TAP1:    x_tap = x0;
      TAP2:    x_tap = x1;
      TAP3:    x_tap = x2;
      default: x_tap = '0;
    endcase
  end

  // Coefficient is unsigned: a zero sign bit makes the signed product exact.
  assign prod = PROD_W'(signed'({1'b0, bus.coef_in})) * PROD_W'(x_tap);
  assign sum  = acc_q + ACC_W'(prod);

`ifdef COEF_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  always_comb begin
    y_fin   = sum;
    sat_hit = 1'b0;
    if (sum > SAT_MAX) begin
      y_fin   = SAT_MAX;
      sat_hit = 1'b1;
    end else if (sum < SAT_MIN) begin
      y_fin   = SAT_MIN;
      sat_hit = 1'b1;
    end
  end
`else
  assign y_fin   = sum;
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = SEL_ZERO;
    acc_d    = acc_q;
    y_d      = y_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_en = 1'b1;
          acc_d    = '0;
          state_d  = TAP1;
          sel_d    = SEL_A1A;
        end
      end
      TAP1: begin
        acc_d   = sum;
        state_d = TAP2;
        sel_d   = SEL_A1M;
      end
      TAP2: begin
        acc_d   = sum;
        state_d = TAP3;
        sel_d   = SEL_A1B;
      end
      TAP3: begin
        y_d     = y_fin;
        ovf_d   = sat_hit;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_ZERO;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.y_out = y_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_coef_mac_seq.sv
// Scoreboard bench for coef_mac_seq with a combinational a1a=1/a1m=2/a1b=3 selector.
module tb_coef_mac_seq;
  import coef_mac_pkg::*;

  localparam int WIDTH  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef struct {
    logic signed [ACC_W-1:0] y;
    logic                    ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  coef_mac_seq_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  coef_mac_seq #(.WIDTH(WIDTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always_comb begin
    bus.coef_in = 4'd0;
    case (bus.sel)
      2'b01:   bus.coef_in = 4'd1;
      2'b10:   bus.coef_in = 4'd2;
      2'b11:   bus.coef_in = 4'd3;
      default: bus.coef_in = 4'd0;
    endcase
  end

  exp_t sb[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int m_x0, m_x1, m_x2;
  logic signed [ACC_W-1:0] last_y;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic void model_clear();
    m_x0 = 0; m_x1 = 0; m_x2 = 0;
    sb.delete();
    last_y = '0;
  endfunction

  function automatic void model_start(int s);
    exp_t e;
    int   full;
    m_x2 = m_x1; m_x1 = m_x0; m_x0 = s;
    full  = 1 * m_x0 + 2 * m_x1 + 3 * m_x2;
    e.ovf = 1'b0;
`ifdef COEF_MAC_SAT_EN
    if (full > 127) begin full = 127; e.ovf = 1'b1; end
    else if (full < -128) begin full = -128; e.ovf = 1'b1; end
`endif
    e.y = ACC_W'(full);
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.sample_in = '0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_start(int s);
    bus.start = 1'b1;
    bus.sample_in = DATA_W'(s);
    model_start(s);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (bus.done === 1'b1);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.sample_in = '0;
    model_clear();
    @(negedge clk);
    checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b, required 00", bus.sel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    checks++; if (bus.y_out !== 16'sd0) begin errors++; $display("FAIL reset_y: got %0d, required 0", bus.y_out); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    do_start(10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.sel !== 2'(i + 1) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL single_tap%0d: sel=%b busy=%b done=%b, required sel=%0d busy=1 done=0",
                 i + 1, bus.sel, bus.busy, bus.done, i + 1);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sel !== 2'b00) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b sel=%b, required 1/0/00", bus.done, bus.busy, bus.sel);
    end else begin
      e = sb.pop_front();
      last_y = e.y;
      checks++;
      if (bus.y_out !== e.y || bus.ovf !== e.ovf) begin
        errors++;
        $display("FAIL single_y: y=%0d ovf=%b, required y=%0d ovf=%b", bus.y_out, bus.ovf, e.y, e.ovf);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe: done=%b one cycle after strobe, required 0", bus.done);
    end
  endtask

  task automatic test_back_to_back(string name, int s0, int s1, int s2);
    exp_t e;
    int   s[3];
    int   cnt0;
    s[0] = s0; s[1] = s1; s[2] = s2;
    do_reset();
    cnt0 = done_cnt;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.sample_in = DATA_W'(s[k]);
      model_start(s[k]);
      @(posedge clk); #1;
      bus.sample_in = 8'sd99;
      if (k == 2) bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b1) begin
        errors++;
        $display("FAIL %s_done%0d: done=%b, required 1", name, k, bus.done);
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        last_y = e.y;
        checks++;
        if (bus.y_out !== e.y || bus.ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s_y%0d: y=%0d ovf=%b, required y=%0d ovf=%b",
                   name, k, bus.y_out, bus.ovf, e.y, e.ovf);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - cnt0 !== 3) begin
      errors++;
      $display("FAIL %s_count: %0d done strobes, required 3", name, done_cnt - cnt0);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    bit   ok;
    int   cnt0;
    do_reset();
    cnt0 = done_cnt;
    do_start(7);
    bus.start = 1'b1;
    bus.sample_in = 8'sd55;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done=%b, required 1", bus.done);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.y_out !== e.y) begin
        errors++;
        $display("FAIL ignore_y: y=%0d, required %0d", bus.y_out, e.y);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - cnt0 !== 1) begin
      errors++;
      $display("FAIL ignore_count: %0d done strobes, required 1", done_cnt - cnt0);
    end
    // A follow-up step exposes whether 55 leaked into the delay line.
    do_start(1);
    wait_done(ok);
    if (ok) begin
      e = sb.pop_front();
      last_y = e.y;
      checks++;
      if (bus.y_out !== e.y) begin
        errors++;
        $display("FAIL ignore_history: y=%0d, required %0d", bus.y_out, e.y);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    int   cnt0;
    do_reset();
    do_start(9);
    wait_done(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (bus.y_out !== e.y) begin
        errors++;
        $display("FAIL midrst_pre_y: y=%0d, required %0d", bus.y_out, e.y);
      end
    end
    do_start(3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_clear();
    cnt0 = done_cnt;
    #1;
    checks++;
    if (bus.sel !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.y_out !== 16'sd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: sel=%b busy=%b done=%b y=%0d ovf=%b, required all 0",
               bus.sel, bus.busy, bus.done, bus.y_out, bus.ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== cnt0) begin
      errors++;
      $display("FAIL midrst_nodone: %0d done strobes, required 0", done_cnt - cnt0);
    end
    do_start(5);
    wait_done(ok);
    if (ok) begin
      e = sb.pop_front();
      last_y = e.y;
      checks++;
      if (bus.y_out !== e.y) begin
        errors++;
        $display("FAIL midrst_post_y: y=%0d, required %0d", bus.y_out, e.y);
      end
    end
  endtask

  task automatic test_idle();
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (bus.sel !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y_out !== last_y) begin
        errors++;
        $display("FAIL idle_hold: sel=%b busy=%b done=%b y=%0d, required 00/0/0/%0d",
                 bus.sel, bus.busy, bus.done, bus.y_out, last_y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back("b2b", 10, 20, 30);
    test_back_to_back("neg", -128, -128, -128);
    test_ignore_start();
    test_reset_mid();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
